// File: rtl/timer_pkg.sv
// Shared constants and types for the clock/countdown timer front end.
// Key indices match the board wiring: KEY1 = adjust, KEY2 = start_stop, KEY3 = mode.
package timer_pkg;

    localparam int CLK_HZ              = 50_000_000;
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;   // 20 ms
    localparam int DEF_REPEAT_DELAY    = 50_000_000;  // 1 s
    localparam int DEF_REPEAT_PERIOD   = 12_500_000;  // 0.25 s
    localparam logic [2:0] DEF_REPEAT_MASK = 3'b010;

    localparam int KEY_ADJUST     = 0;
    localparam int KEY_START_STOP = 1;
    localparam int KEY_MODE       = 2;

    typedef enum logic [1:0] {
        KS_IDLE   = 2'd0,
        KS_HOLD   = 2'd1,
        KS_REPEAT = 2'd2
    } key_state_e;

    // A one-cycle count still needs a one-bit register.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_channel.sv
// One pushbutton: synchroniser, debounce filter, press/repeat FSM.
// Emits a single-cycle pulse per accepted press, plus repeats when REPEAT_EN is set.
module key_channel
    import timer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter bit REPEAT_EN       = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    output logic key_pulse,
    output logic key_level
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int RW = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [DW-1:0] D_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

    logic [1:0]    sync_q;
    logic [1:0]    prime_q;
    logic          armed_q, armed_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          stable_q, stable_d;
    logic          level_q;
    key_state_e    state_q, state_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          pulse_q, pulse_d;
    logic          s;

    assign s = ~sync_q[1];

    // The channel stays disarmed until a real release has been seen after reset,
    // so a key held through reset is not accepted when reset lifts.
    always_comb begin
        armed_d  = armed_q | (prime_q[1] & ~s);
        dcnt_d   = '0;
        stable_d = stable_q;
        if (armed_q && (s != stable_q)) begin
            if (dcnt_q == D_LAST) begin
                stable_d = s;
            end else if (dcnt_q != {DW{1'b1}}) begin
                dcnt_d = dcnt_q + 1'b1;
            end else begin
                dcnt_d = dcnt_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        pulse_d = 1'b0;
        case (state_q)
            KS_IDLE: begin
                if (level_q) begin
                    pulse_d = 1'b1;
                    state_d = KS_HOLD;
                    rcnt_d  = '0;
                end
            end
            KS_HOLD: begin
                if (!level_q) begin
                    state_d = KS_IDLE;
                    rcnt_d  = '0;
                end else if (REPEAT_EN) begin
                    if (rcnt_q == RD_LAST) begin
                        pulse_d = 1'b1;
                        state_d = KS_REPEAT;
                        rcnt_d  = '0;
                    end else if (rcnt_q != {RW{1'b1}}) begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
            end
            KS_REPEAT: begin
                if (!level_q) begin
                    state_d = KS_IDLE;
                    rcnt_d  = '0;
                end else if (rcnt_q == RP_LAST) begin
                    pulse_d = 1'b1;
                    rcnt_d  = '0;
                end else if (rcnt_q != {RW{1'b1}}) begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = KS_IDLE;
                rcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q   <= 2'b11;
            prime_q  <= 2'b00;
            armed_q  <= 1'b0;
            dcnt_q   <= '0;
            stable_q <= 1'b0;
            level_q  <= 1'b0;
            state_q  <= KS_IDLE;
            rcnt_q   <= '0;
            pulse_q  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], key_n};
            prime_q  <= {prime_q[0], 1'b1};
            armed_q  <= armed_d;
            dcnt_q   <= dcnt_d;
            stable_q <= stable_d;
            level_q  <= stable_q;
            state_q  <= state_d;
            rcnt_q   <= rcnt_d;
            pulse_q  <= pulse_d;
        end
    end

    assign key_pulse = pulse_q;
    assign key_level = level_q;

endmodule

// File: rtl/key_conditioner.sv
// Conditions the raw active-low board keys into debounced levels and press pulses
// for the timer FSM; each key is an independent key_channel.
module key_conditioner
    import timer_pkg::*;
#(
    parameter int                N_KEYS          = 3,
    parameter int                DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int                REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int                REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter logic [N_KEYS-1:0] REPEAT_MASK     = N_KEYS'(DEF_REPEAT_MASK)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] key_pulse,
    output logic [N_KEYS-1:0] key_level,
    output logic              any_held
);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD),
            .REPEAT_EN      (REPEAT_MASK[i])
        ) u_channel (
            .clock    (clock),
            .reset    (reset),
            .key_n    (key_n[i]),
            .key_pulse(key_pulse[i]),
            .key_level(key_level[i])
        );
    end

    assign any_held = |key_level;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with short debounce/repeat constants
// (debounce 4, repeat delay 10, repeat period 3, repeat on key 1 only).
module tb_key_conditioner;

    typedef struct {
        logic [2:0] keyN;
        logic [2:0] expPulse;
        logic [2:0] expLevel;
        string      name;
    } vec_t;

    logic       clock;
    logic       reset;
    logic [2:0] keyN;
    logic [2:0] key_pulse;
    logic [2:0] key_level;
    logic       any_held;

    int tests = 0;
    int fails = 0;
    int seenEdges[$];
    vec_t vecs[$];

    key_conditioner #(
        .N_KEYS         (3),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3),
        .REPEAT_MASK    (3'b010)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .key_n    (keyN),
        .key_pulse(key_pulse),
        .key_level(key_level),
        .any_held (any_held)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive the keys ahead of the next rising edge, then step just past it.
    task automatic applyStimulus(input logic [2:0] k);
        keyN = k;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [2:0] expPulse, input logic [2:0] expLevel);
        logic expAny;
        expAny = |expLevel;
        tests++;
        if (key_pulse !== expPulse || key_level !== expLevel || any_held !== expAny) begin
            fails++;
            $display("[TB] FAIL %s: got pulse=%b level=%b any=%b, expected pulse=%b level=%b any=%b",
                     name, key_pulse, key_level, any_held, expPulse, expLevel, expAny);
        end
    endtask

    task automatic checkValue(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Press the masked keys for 10 edges, then release for 8; first sample is edge 0.
    task automatic pressAndCheck(input string name, input logic [2:0] mask);
        for (int e = 0; e < 18; e++) begin
            applyStimulus((e < 10) ? ~mask : 3'b111);
            checkOutput($sformatf("%s_e%0d", name, e),
                        (e == 7) ? mask : 3'b000,
                        (e >= 6 && e < 16) ? mask : 3'b000);
        end
    endtask

    // Hold one key for edges 0..30 and log the edges where its pulse is high.
    task automatic holdKey(input int idx);
        logic [2:0] k;
        seenEdges.delete();
        for (int e = 0; e < 46; e++) begin
            k = 3'b111;
            if (e < 31) k[idx] = 1'b0;
            applyStimulus(k);
            if (key_pulse[idx]) seenEdges.push_back(e);
        end
    endtask

    initial begin
        vec_t v;
        int   pulseCount;
        int   pulseEdge;
        int   expRep[8];

        expRep = '{7, 17, 20, 23, 26, 29, 32, 35};

        // Clean press on key 2: level after edge 6, pulse after edge 7, release at edge 8.
        for (int c = 0; c < 17; c++) begin
            v.keyN     = (c < 8) ? 3'b011 : 3'b111;
            v.expLevel = (c >= 6 && c < 14) ? 3'b100 : 3'b000;
            v.expPulse = (c == 7) ? 3'b100 : 3'b000;
            v.name     = $sformatf("clean_e%0d", c);
            vecs.push_back(v);
        end
        // Three-cycle glitch on key 1 must never be accepted.
        for (int c = 0; c < 10; c++) begin
            v.keyN     = (c < 3) ? 3'b101 : 3'b111;
            v.expLevel = 3'b000;
            v.expPulse = 3'b000;
            v.name     = $sformatf("glitch_e%0d", c);
            vecs.push_back(v);
        end

        keyN  = 3'b111;
        reset = 1'b0;
        #12;
        checkOutput("reset_state", 3'b000, 3'b000);
        @(posedge clock);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) applyStimulus(3'b111);
        checkOutput("idle_after_reset", 3'b000, 3'b000);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].keyN);
            checkOutput(vecs[i].name, vecs[i].expPulse, vecs[i].expLevel);
        end

        // Bounce on key 0, then a steady press; the pulse lands 7 edges after the last fall.
        pulseCount = 0;
        pulseEdge  = -1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(((i / 2) % 2 == 0) ? 3'b110 : 3'b111);
            if (key_pulse != 3'b000) pulseCount++;
        end
        for (int e = 0; e < 15; e++) begin
            applyStimulus(3'b110);
            if (key_pulse[0]) begin
                pulseCount++;
                pulseEdge = e;
            end
        end
        checkValue("bounce_pulse_count", pulseCount, 1);
        checkValue("bounce_pulse_edge", pulseEdge, 7);
        for (int i = 0; i < 10; i++) applyStimulus(3'b111);
        checkOutput("bounce_released", 3'b000, 3'b000);

        // Auto-repeat on key 1; release lands exactly where edge 38 would have repeated.
        holdKey(1);
        checkValue("repeat_count", seenEdges.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < seenEdges.size())
                checkValue($sformatf("repeat_edge%0d", i), seenEdges[i], expRep[i]);
        end

        // Same hold on key 2, which has no auto-repeat.
        holdKey(2);
        checkValue("norepeat_count", seenEdges.size(), 1);
        checkValue("norepeat_edge", (seenEdges.size() > 0) ? seenEdges[0] : -1, 7);

        // Coincident presses on keys 0 and 2, then staggered releases.
        pressAndCheck("simul", 3'b101);
        for (int e = 0; e < 24; e++) begin
            applyStimulus({(e >= 14), 1'b1, (e >= 10)});
            checkOutput($sformatf("stagger_e%0d", e),
                        (e == 7) ? 3'b101 : 3'b000,
                        {(e >= 6 && e < 20), 1'b0, (e >= 6 && e < 16)});
        end

        // Reset during key 1 debounce, key held through reset release.
        for (int i = 0; i < 3; i++) applyStimulus(3'b101);
        reset = 1'b0;
        #1;
        checkOutput("reset_mid_debounce", 3'b000, 3'b000);
        @(posedge clock);
        #1;
        reset = 1'b1;
        for (int e = 0; e < 15; e++) begin
            applyStimulus(3'b101);
            checkOutput($sformatf("held_after_reset1_e%0d", e), 3'b000, 3'b000);
        end
        for (int i = 0; i < 8; i++) applyStimulus(3'b111);
        pressAndCheck("repress1", 3'b010);

        // Reset while key 1 is auto-repeating (edge 20 carries a repeat pulse).
        for (int e = 0; e < 21; e++) applyStimulus(3'b101);
        checkOutput("repeat_before_reset", 3'b010, 3'b010);
        reset = 1'b0;
        #1;
        checkOutput("reset_mid_repeat", 3'b000, 3'b000);
        @(posedge clock);
        #1;
        reset = 1'b1;
        for (int e = 0; e < 20; e++) begin
            applyStimulus(3'b101);
            checkOutput($sformatf("held_after_reset2_e%0d", e), 3'b000, 3'b000);
        end
        for (int i = 0; i < 8; i++) applyStimulus(3'b111);
        pressAndCheck("repress2", 3'b010);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
